// File: rtl/slicer_pkg.sv
// Shared types for the slicer job scheduler: FSM states, completion codes
// and the slice codes the slicer accepts.
package slicer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    RUN,
    FLUSH
  } state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_ABORTED = 2'b11
  } done_status_e;

  localparam int          N_LEGAL_SLICES                = 5;
  localparam logic [31:0] LEGAL_SLICES [N_LEGAL_SLICES] = '{32'd0, 32'd1, 32'd2, 32'd4, 32'd8};

  // A zero-length job with no constellation would never produce slicer activity.
  function automatic logic job_is_legal(input logic [31:0] slice,
                                        input logic [31:0] length,
                                        input logic [3:0]  constellation);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_SLICES; i++) begin
      if (slice == LEGAL_SLICES[i]) ok = 1'b1;
    end
    if (constellation == 4'd0 && length == 32'd0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/slicer_job_scheduler_if.sv
// Requester-side bus of the slicer job scheduler: two packed request lanes
// plus the shared completion report.
interface slicer_job_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_slice;
  logic [63:0] req_length;
  logic [7:0]  req_constellation;
  logic        done_valid;
  logic        done_id;
  logic [1:0]  done_status;

  modport master (
    output req_valid, req_slice, req_length, req_constellation,
    input  req_ready, done_valid, done_id, done_status
  );

  modport slave (
    input  req_valid, req_slice, req_length, req_constellation,
    output req_ready, done_valid, done_id, done_status
  );
endinterface

// File: rtl/slicer_job_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// only moves when a grant is issued (grant implies handshake here).
module rr_arb2 (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    if (gnt[1])      last_d = 1'b1;
    else if (gnt[0]) last_d = 1'b0;
  end

  // Pointer starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (srst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/slicer_job_scheduler.sv
// Accepts jobs from two requesters, configures the slicer, supervises its
// start/finish and reports one completion per accepted job.
module slicer_job_scheduler
  import slicer_pkg::*;
#(
  parameter int START_TIMEOUT = 16,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  srst,
  slicer_job_scheduler_if.slave req_if,
  input  logic                  abort,
  output logic [31:0]           cfg_slice,
  output logic [31:0]           cfg_length,
  output logic [3:0]            cfg_constellation,
  output logic                  cfg_valid,
  input  logic                  slicer_busy,
  output logic                  dma_reset,
  output logic                  sched_busy
);

  localparam int              TW     = $clog2(START_TIMEOUT + 1);
  localparam int              FW     = $clog2(FLUSH_CYCLES + 1);
  localparam logic [TW-1:0]   T_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0]   T_MAX  = TW'(START_TIMEOUT);
  localparam logic [FW-1:0]   F_LAST = FW'(FLUSH_CYCLES - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          id_q, id_d;
  logic [31:0]   cfg_slice_q, cfg_slice_d, cfg_length_q, cfg_length_d;
  logic [3:0]    cfg_const_q, cfg_const_d;
  logic          cfg_valid_q, cfg_valid_d, dma_reset_q, dma_reset_d;
  logic          done_valid_q, done_valid_d, done_id_q, done_id_d;
  logic [1:0]    done_status_q, done_status_d;

  logic          arb_en, hs, gid, g_legal;
  logic [1:0]    gnt;
  logic [31:0]   g_slice, g_length;
  logic [3:0]    g_const;

  assign arb_en = (state_q == IDLE) && !srst;

  rr_arb2 u_arb (
    .clk  (clk),
    .srst (srst),
    .en   (arb_en),
    .req  (req_if.req_valid),
    .gnt  (gnt)
  );

  assign req_if.req_ready   = gnt;
  assign req_if.done_valid  = done_valid_q;
  assign req_if.done_id     = done_id_q;
  assign req_if.done_status = done_status_q;
  assign cfg_slice          = cfg_slice_q;
  assign cfg_length         = cfg_length_q;
  assign cfg_constellation  = cfg_const_q;
  assign cfg_valid          = cfg_valid_q;
  assign dma_reset          = dma_reset_q;
  assign sched_busy         = (state_q != IDLE);

  always_comb begin
    hs       = |gnt;
    gid      = gnt[1];
    g_slice  = gid ? req_if.req_slice[63:32]  : req_if.req_slice[31:0];
    g_length = gid ? req_if.req_length[63:32] : req_if.req_length[31:0];
    g_const  = gid ? req_if.req_constellation[7:4] : req_if.req_constellation[3:0];
    g_legal  = job_is_legal(g_slice, g_length, g_const);

    state_d       = state_q;
    tcnt_d        = tcnt_q;
    fcnt_d        = fcnt_q;
    id_d          = id_q;
    cfg_slice_d   = cfg_slice_q;
    cfg_length_d  = cfg_length_q;
    cfg_const_d   = cfg_const_q;
    cfg_valid_d   = 1'b0;
    dma_reset_d   = 1'b0;
    done_valid_d  = 1'b0;
    done_id_d     = done_id_q;
    done_status_d = done_status_q;

    // Abort overrides every other event of an active job, including a busy fall.
    if (abort && (state_q inside {ISSUE, WAIT_START, RUN})) begin
      state_d     = FLUSH;
      fcnt_d      = '0;
      dma_reset_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            cfg_slice_d  = g_slice;
            cfg_length_d = g_length;
            cfg_const_d  = g_const;
            id_d         = gid;
            if (g_legal) begin
              state_d     = ISSUE;
              cfg_valid_d = 1'b1;
            end else begin
              done_valid_d  = 1'b1;
              done_id_d     = gid;
              done_status_d = ST_ILLEGAL;
            end
          end
        end
        ISSUE: begin
          state_d = WAIT_START;
          tcnt_d  = '0;
        end
        WAIT_START: begin
          if (slicer_busy) begin
            state_d = RUN;
          end else if (tcnt_q == T_LAST) begin
            state_d       = IDLE;
            done_valid_d  = 1'b1;
            done_id_d     = id_q;
            done_status_d = ST_TIMEOUT;
          end else if (tcnt_q != T_MAX) begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!slicer_busy) begin
            state_d       = IDLE;
            done_valid_d  = 1'b1;
            done_id_d     = id_q;
            done_status_d = ST_OK;
          end
        end
        FLUSH: begin
          if (fcnt_q == F_LAST) begin
            state_d       = IDLE;
            done_valid_d  = 1'b1;
            done_id_d     = id_q;
            done_status_d = ST_ABORTED;
          end else begin
            fcnt_d      = fcnt_q + 1'b1;
            dma_reset_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      fcnt_q        <= '0;
      id_q          <= 1'b0;
      cfg_slice_q   <= '0;
      cfg_length_q  <= '0;
      cfg_const_q   <= '0;
      cfg_valid_q   <= 1'b0;
      dma_reset_q   <= 1'b0;
      done_valid_q  <= 1'b0;
      done_id_q     <= 1'b0;
      done_status_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      fcnt_q        <= fcnt_d;
      id_q          <= id_d;
      cfg_slice_q   <= cfg_slice_d;
      cfg_length_q  <= cfg_length_d;
      cfg_const_q   <= cfg_const_d;
      cfg_valid_q   <= cfg_valid_d;
      dma_reset_q   <= dma_reset_d;
      done_valid_q  <= done_valid_d;
      done_id_q     <= done_id_d;
      done_status_q <= done_status_d;
    end
  end

endmodule

// File: tb/tb_slicer_job_scheduler.sv
// Bench for slicer_job_scheduler: each job is described as a timeline relative
// to its handshake cycle, and every output is compared against that timeline.
module tb_slicer_job_scheduler;

  localparam int ST = 16;
  localparam int FC = 2;
  localparam int K_OK = 0, K_TIMEOUT = 1, K_ABORT = 2;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        abort = 1'b0;
  logic        slicer_busy = 1'b0;
  logic [31:0] cfg_slice, cfg_length;
  logic [3:0]  cfg_constellation;
  logic        cfg_valid, dma_reset, sched_busy;

  slicer_job_scheduler_if bus ();

  slicer_job_scheduler #(.START_TIMEOUT(ST), .FLUSH_CYCLES(FC)) dut (
    .clk               (clk),
    .srst              (srst),
    .req_if            (bus),
    .abort             (abort),
    .cfg_slice         (cfg_slice),
    .cfg_length        (cfg_length),
    .cfg_constellation (cfg_constellation),
    .cfg_valid         (cfg_valid),
    .slicer_busy       (slicer_busy),
    .dma_reset         (dma_reset),
    .sched_busy        (sched_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int fails = 0;
  bit rr_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_legal(input logic [31:0] sl, input logic [31:0] ln, input logic [3:0] cs);
    return (sl inside {32'd0, 32'd1, 32'd2, 32'd4, 32'd8}) && !(cs == 4'd0 && ln == 32'd0);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.req_ready, 0);
    chk({tag, "_cfg_slice"}, cfg_slice, 0);
    chk({tag, "_cfg_length"}, cfg_length, 0);
    chk({tag, "_cfg_const"}, cfg_constellation, 0);
    chk({tag, "_cfg_valid"}, cfg_valid, 0);
    chk({tag, "_dma_reset"}, dma_reset, 0);
    chk({tag, "_done_valid"}, bus.done_valid, 0);
    chk({tag, "_done_id"}, bus.done_id, 0);
    chk({tag, "_done_status"}, bus.done_status, 0);
    chk({tag, "_sched_busy"}, sched_busy, 0);
  endtask

  // Job timeline, rel = cycles since handshake: ISSUE at 1, WAIT_START entry at 2.
  // Busy is high for rel in [2+d, 1+d+r]; abort is driven at rel a=1+k and a+1.
  task automatic run_job(input int rq, input logic [31:0] sl, input logic [31:0] ln,
                         input logic [3:0] cs, input int kind, input int d, input int r, input int k);
    int dn, a;
    bit legal;
    logic [1:0] st;
    legal = model_legal(sl, ln, cs);
    a = 1 + k;
    if (!legal)                begin dn = 1;           st = 2'b01; end
    else if (kind == K_OK)     begin dn = 3 + d + r;   st = 2'b00; end
    else if (kind == K_TIMEOUT) begin dn = 2 + ST;     st = 2'b10; end
    else                       begin dn = a + 1 + FC;  st = 2'b11; end
    bus.req_slice         = {$urandom, $urandom};
    bus.req_length        = {$urandom, $urandom};
    bus.req_constellation = 8'($urandom);
    bus.req_slice[32*rq +: 32]       = sl;
    bus.req_length[32*rq +: 32]      = ln;
    bus.req_constellation[4*rq +: 4] = cs;
    for (int rel = 0; rel <= dn; rel++) begin
      if (rel == 0)                  bus.req_valid = 2'(1 << rq);
      else if (legal && rel < dn)    bus.req_valid = 2'(1 << (1 - rq));
      else                           bus.req_valid = 2'b00;
      slicer_busy = legal && (kind != K_TIMEOUT) && rel >= 2 + d && rel <= 1 + d + r
                    && !(kind == K_ABORT && rel > a);
      abort = legal && (kind == K_ABORT) && (rel == a || rel == a + 1);
      #3;
      if (rel == 0) begin
        chk("grant", bus.req_ready, 32'(1 << rq));
        rr_last = rq[0];
      end else begin
        chk("ready_busy", bus.req_ready, 0);
      end
      chk("cfg_valid", cfg_valid, legal && rel == 1);
      if (legal && rel >= 1) begin
        chk("cfg_slice", cfg_slice, sl);
        chk("cfg_length", cfg_length, ln);
        chk("cfg_const", cfg_constellation, cs);
      end
      chk("dma_reset", dma_reset, legal && kind == K_ABORT && rel > a && rel <= a + FC);
      chk("sched_busy", sched_busy, legal && rel >= 1 && rel < dn);
      chk("done_valid", bus.done_valid, rel == dn);
      if (rel == dn) begin
        chk("done_id", bus.done_id, rq);
        chk("done_status", bus.done_status, st);
      end
      next_cycle();
    end
    abort       = 1'b0;
    slicer_busy = 1'b0;
    bus.req_valid = 2'b00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_g;
    logic        prev_id;
    logic [31:0] sl;
    logic [31:0] ln;
    logic [3:0]  cs;
    int          kind, d, r, k, pick;

    bus.req_valid = 2'b11;
    bus.req_slice = '0;
    bus.req_length = '0;
    bus.req_constellation = '0;
    next_cycle();
    next_cycle();
    #3;
    chk_all_zero("reset");
    bus.req_valid = 2'b00;
    srst = 1'b0;
    next_cycle();

    run_job(0, 32'd4, 32'd64, 4'd0, K_OK, 1, 70, 0);
    run_job(1, 32'd3, 32'd77, 4'd2, K_OK, 0, 1, 0);
    run_job(1, 32'd8, 32'd5, 4'd3, K_TIMEOUT, 0, 0, 0);
    run_job(0, 32'd2, 32'd100, 4'd6, K_ABORT, 3, 4, 8);
    run_job(1, 32'd1, 32'd9, 4'd1, K_ABORT, 0, 10, 5);
    run_job(0, 32'd0, 32'd12, 4'd4, K_ABORT, 2, 3, 0);
    run_job(0, 32'd4, 32'd0, 4'd0, K_OK, 0, 2, 0);
    run_job(1, 32'd2, 32'd33, 4'd5, K_OK, ST - 1, 3, 0);

    // Abort while idle must have no effect.
    abort = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("idle_abort_dma", dma_reset, 0);
      chk("idle_abort_done", bus.done_valid, 0);
      chk("idle_abort_busy", sched_busy, 0);
      next_cycle();
    end
    abort = 1'b0;

    for (int j = 0; j < 24; j++) begin
      pick = $urandom_range(9, 0);
      sl = (pick < 7) ? 32'(1 << $urandom_range(3, 0)) : 32'($urandom_range(15, 5));
      if (pick == 0) sl = 32'd0;
      ln = (pick == 9) ? 32'd0 : $urandom;
      cs = (pick == 9) ? 4'd0 : 4'($urandom);
      kind = $urandom_range(2, 0);
      d = $urandom_range(ST - 1, 0);
      r = $urandom_range(6, 1);
      k = $urandom_range(1 + d + r, 0);
      run_job($urandom_range(1, 0), sl, ln, cs, kind, d, r, k);
    end

    // Reset in the middle of a running job.
    bus.req_slice = {32'd0, 32'd2};
    bus.req_length = {32'd0, 32'd10};
    bus.req_constellation = 8'h03;
    bus.req_valid = 2'b01;
    #3;
    chk("srst_job_grant", bus.req_ready, 2'b01);
    next_cycle();
    bus.req_valid = 2'b00;
    next_cycle();
    slicer_busy = 1'b1;
    next_cycle();
    next_cycle();
    #3;
    chk("srst_job_running", sched_busy, 1);
    srst = 1'b1;
    next_cycle();
    srst = 1'b0;
    #3;
    chk_all_zero("srst_mid");
    next_cycle();
    slicer_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("srst_no_done", bus.done_valid, 0);
      chk("srst_no_dma", dma_reset, 0);
      next_cycle();
    end
    rr_last = 1'b1;

    // Both requesters continuously valid with illegal jobs: one grant per cycle.
    bus.req_slice = {32'd5, 32'd3};
    bus.req_valid = 2'b11;
    prev_id = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #3;
      exp_g = rr_last ? 2'b01 : 2'b10;
      chk("rr_grant", bus.req_ready, exp_g);
      chk("rr_grant_seq", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_done_valid", bus.done_valid, i > 0);
      if (i > 0) begin
        chk("rr_done_id", bus.done_id, prev_id);
        chk("rr_done_status", bus.done_status, 2'b01);
      end
      prev_id = exp_g[1];
      rr_last = exp_g[1];
      next_cycle();
    end
    bus.req_valid = 2'b00;
    #3;
    chk("rr_last_done", bus.done_valid, 1);
    chk("rr_last_id", bus.done_id, prev_id);
    chk("rr_cfg_valid", cfg_valid, 0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
